// File: rtl/commit_write_scheduler_pkg.sv
// Shared types for the commit write scheduler: register/tag widths, the queued
// commit entry and the rollback ordering states.
package commit_write_scheduler_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_W     = 4;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      val;
    logic [ROB_W-1:0]     rob;
  } commit_entry_t;

  localparam int unsigned ENTRY_W = $bits(commit_entry_t);

  typedef enum logic [0:0] {
    StIdle,
    StRbPend
  } rb_state_e;

  // Number of writes accepted in a cycle, as a 2-bit count.
  function automatic logic [1:0] count_writes(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/commit_write_scheduler_wb_queue.sv
// Circular write-back buffer: up to 2 pushes and 1 pop per cycle, plus two
// youngest-first lookup ports over the stored entries.
module wb_queue_2in1out
  import commit_write_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push0,
  input  logic [ENTRY_W-1:0]   push0_entry,
  input  logic                 push1,
  input  logic [ENTRY_W-1:0]   push1_entry,
  input  logic                 pop,
  output logic [ENTRY_W-1:0]   head,
  output logic [CNT_W-1:0]     count,
  input  logic [REG_IDX_W-1:0] lk0_index,
  output logic                 lk0_hit,
  output logic [XLEN-1:0]      lk0_val,
  input  logic [REG_IDX_W-1:0] lk1_index,
  output logic                 lk1_hit,
  output logic [XLEN-1:0]      lk1_val
);

  commit_entry_t    mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       push_n;

  always_comb begin
    push_n  = count_writes(push0, push1);
    tail_d  = tail_q + PTR_W'(push_n);
    head_d  = head_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push0) mem_q[tail_q] <= commit_entry_t'(push0_entry);
    if (push1) mem_q[tail_q + PTR_W'(1)] <= commit_entry_t'(push1_entry);
  end

  // Walk oldest to youngest so the youngest matching entry is the last to overwrite.
  function automatic logic [XLEN:0] lookup(input logic [REG_IDX_W-1:0] idx);
    logic [XLEN:0]    res;
    logic [PTR_W-1:0] slot;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + PTR_W'(k);
      if (CNT_W'(k) < count_q && idx != '0 && mem_q[slot].rd == idx) begin
        res = {1'b1, mem_q[slot].val};
      end
    end
    return res;
  endfunction

  assign {lk0_hit, lk0_val} = lookup(lk0_index);
  assign {lk1_hit, lk1_val} = lookup(lk1_index);

  assign head  = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/commit_write_scheduler.sv
// Dual-retire to single-port register file commit scheduler with decode bypass
// and rollback ordered behind all pending writes.
module commit_write_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             c0_valid,
  input  logic [4:0]       c0_rd,
  input  logic [31:0]      c0_val,
  input  logic [ROB_W-1:0] c0_rob,
  input  logic             c1_valid,
  input  logic [4:0]       c1_rd,
  input  logic [31:0]      c1_val,
  input  logic [ROB_W-1:0] c1_rob,
  output logic             commit_ready,
  input  logic             rollback_in,
  output logic             rf_commit_config,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_val,
  output logic [ROB_W-1:0] rf_rob,
  output logic             rf_rollback,
  input  logic [4:0]       rs1_index,
  output logic             rs1_hit,
  output logic [31:0]      rs1_val,
  input  logic [4:0]       rs2_index,
  output logic             rs2_hit,
  output logic [31:0]      rs2_val,
  output logic             decode_stall
);
  import commit_write_scheduler_pkg::commit_entry_t;
  import commit_write_scheduler_pkg::rb_state_e;
  import commit_write_scheduler_pkg::StIdle;
  import commit_write_scheduler_pkg::StRbPend;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rb_state_e        state_q, state_d;
  logic             rb_pend;
  logic [CNT_W-1:0] count;
  logic             keep0, keep1, push0, push1, pop;
  commit_entry_t    c0_ent, c1_ent, push0_ent, head;

  assign rb_pend      = (state_q == StRbPend);
  assign commit_ready = rdy && !rb_pend && ((CNT_W'(DEPTH) - count) >= CNT_W'(2));
  assign decode_stall = rollback_in || rb_pend;

  // x0 writes are architecturally void; compact survivors so c0 stays older.
  always_comb begin
    c0_ent    = '{rd: c0_rd, val: c0_val, rob: c0_rob};
    c1_ent    = '{rd: c1_rd, val: c1_val, rob: c1_rob};
    keep0     = commit_ready && c0_valid && (c0_rd != '0);
    keep1     = commit_ready && c0_valid && c1_valid && (c1_rd != '0);
    push0     = keep0 || keep1;
    push1     = keep0 && keep1;
    push0_ent = keep0 ? c0_ent : c1_ent;
  end

  assign pop = rdy && (count != '0);

  wb_queue_2in1out #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push0      (push0),
    .push0_entry(push0_ent),
    .push1      (push1),
    .push1_entry(c1_ent),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .lk0_index  (rs1_index),
    .lk0_hit    (rs1_hit),
    .lk0_val    (rs1_val),
    .lk1_index  (rs2_index),
    .lk1_hit    (rs2_hit),
    .lk1_val    (rs2_val)
  );

  assign rf_commit_config = pop;
  assign rf_rd            = pop ? head.rd  : '0;
  assign rf_val           = pop ? head.val : '0;
  assign rf_rob           = pop ? head.rob : '0;

  // Rollback is released only once the last pending write drains this cycle.
  always_comb begin
    state_d     = state_q;
    rf_rollback = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rollback_in) state_d = StRbPend;
      end
      StRbPend: begin
        if (rdy && (count == '0 || (count == CNT_W'(1) && pop))) begin
          rf_rollback = 1'b1;
          state_d     = StIdle;
        end
        if (rollback_in) state_d = StRbPend;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_commit_write_scheduler.sv
// Self-checking bench for commit_write_scheduler: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_commit_write_scheduler;

  localparam int DEPTH = 4;

  logic        clk, rst, rdy;
  logic        c0_valid, c1_valid, rollback_in;
  logic [4:0]  c0_rd, c1_rd, rs1_index, rs2_index, rf_rd;
  logic [31:0] c0_val, c1_val, rf_val, rs1_val, rs2_val;
  logic [3:0]  c0_rob, c1_rob, rf_rob;
  logic        commit_ready, rf_commit_config, rf_rollback;
  logic        rs1_hit, rs2_hit, decode_stall;

  commit_write_scheduler #(
    .DEPTH(DEPTH),
    .ROB_W(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .c0_valid        (c0_valid),
    .c0_rd           (c0_rd),
    .c0_val          (c0_val),
    .c0_rob          (c0_rob),
    .c1_valid        (c1_valid),
    .c1_rd           (c1_rd),
    .c1_val          (c1_val),
    .c1_rob          (c1_rob),
    .commit_ready    (commit_ready),
    .rollback_in     (rollback_in),
    .rf_commit_config(rf_commit_config),
    .rf_rd           (rf_rd),
    .rf_val          (rf_val),
    .rf_rob          (rf_rob),
    .rf_rollback     (rf_rollback),
    .rs1_index       (rs1_index),
    .rs1_hit         (rs1_hit),
    .rs1_val         (rs1_val),
    .rs2_index       (rs2_index),
    .rs2_hit         (rs2_hit),
    .rs2_val         (rs2_val),
    .decode_stall    (decode_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (!(c1_valid && !c0_valid)) else $error("c1_valid driven without c0_valid");
  end

  int           errors = 0;
  int           checks = 0;
  logic [127:0] got, want;

  // Reference model: list of pending writes, oldest at index 0.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  rob;
  } ent_t;
  ent_t mq[$];
  bit   m_rb;

  logic        exp_ready, exp_wr, exp_rb, exp_stall, exp_h1, exp_h2;
  logic [4:0]  exp_rd;
  logic [31:0] exp_val, exp_v1, exp_v2;
  logic [3:0]  exp_rob;

  task automatic model_eval();
    int n;
    n         = mq.size();
    exp_ready = rdy && ((DEPTH - n) >= 2) && !m_rb;
    exp_wr    = rdy && (n != 0);
    exp_rd    = exp_wr ? mq[0].rd  : 5'd0;
    exp_val   = exp_wr ? mq[0].val : 32'd0;
    exp_rob   = exp_wr ? mq[0].rob : 4'd0;
    exp_rb    = m_rb && rdy && (n == 0 || (n == 1 && exp_wr));
    exp_stall = rollback_in || m_rb;
    exp_h1 = 1'b0; exp_v1 = 32'd0; exp_h2 = 1'b0; exp_v2 = 32'd0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!exp_h1 && rs1_index != 5'd0 && mq[i].rd == rs1_index) begin
        exp_h1 = 1'b1; exp_v1 = mq[i].val;
      end
      if (!exp_h2 && rs2_index != 5'd0 && mq[i].rd == rs2_index) begin
        exp_h2 = 1'b1; exp_v2 = mq[i].val;
      end
    end
  endtask

  task automatic model_update();
    ent_t e;
    if (rst) begin
      mq.delete();
      m_rb = 1'b0;
    end else begin
      if (exp_wr) void'(mq.pop_front());
      if (exp_ready && c0_valid) begin
        if (c0_rd != 5'd0) begin
          e.rd = c0_rd; e.val = c0_val; e.rob = c0_rob; mq.push_back(e);
        end
        if (c1_valid && c1_rd != 5'd0) begin
          e.rd = c1_rd; e.val = c1_val; e.rob = c1_rob; mq.push_back(e);
        end
      end
      m_rb = rollback_in || (m_rb && !exp_rb);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; rdy = 1'b1; rollback_in = 1'b0;
    c0_valid = 1'b0; c0_rd = '0; c0_val = '0; c0_rob = '0;
    c1_valid = 1'b0; c1_rd = '0; c1_val = '0; c1_rob = '0;
    rs1_index = '0; rs2_index = '0;
  endtask

  task automatic retire(input logic [4:0] r0, input logic [31:0] v0, input logic [3:0] t0,
                        input logic two, input logic [4:0] r1, input logic [31:0] v1,
                        input logic [3:0] t1);
    c0_valid = 1'b1; c0_rd = r0; c0_val = v0; c0_rob = t0;
    c1_valid = two;  c1_rd = r1; c1_val = v1; c1_rob = t1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    settle(); tick();
    rst = 1'b0;
    settle();
    got  = 128'({commit_ready, rf_commit_config, rf_rd, rf_val, rf_rob, rf_rollback,
                 rs1_hit, rs2_hit, decode_stall});
    want = 128'({1'b1, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    checks++;
    if (got !== want) begin errors++; $display("FAIL reset_state: got %h want %h", got, want); end
    tick();
  endtask

  task automatic test_dual_retire();
    clear_inputs();
    retire(5'd5, 32'h11, 4'd3, 1'b1, 5'd6, 32'h22, 4'd4);
    settle();
    checks++;
    if (rf_commit_config !== 1'b0) begin
      errors++; $display("FAIL dual_no_same_cycle_write: got %b want 0", rf_commit_config);
    end
    tick();
    clear_inputs();
    settle();
    got = 128'({rf_commit_config, rf_rd, rf_val, rf_rob});
    want = 128'({1'b1, 5'd5, 32'h11, 4'd3});
    checks++;
    if (got !== want) begin errors++; $display("FAIL dual_write0: got %h want %h", got, want); end
    tick();
    settle();
    got = 128'({rf_commit_config, rf_rd, rf_val, rf_rob});
    want = 128'({1'b1, 5'd6, 32'h22, 4'd4});
    checks++;
    if (got !== want) begin errors++; $display("FAIL dual_write1: got %h want %h", got, want); end
    tick();
    settle();
    got = 128'({rf_commit_config, commit_ready});
    want = 128'({1'b0, 1'b1});
    checks++;
    if (got !== want) begin errors++; $display("FAIL dual_drained: got %h want %h", got, want); end
    tick();
  endtask

  task automatic test_zero_filter();
    clear_inputs();
    retire(5'd0, 32'h99, 4'd1, 1'b1, 5'd7, 32'h7, 4'd2);
    settle(); tick();
    clear_inputs();
    settle();
    got = 128'({rf_commit_config, rf_rd, rf_val, rf_rob});
    want = 128'({1'b1, 5'd7, 32'h7, 4'd2});
    checks++;
    if (got !== want) begin errors++; $display("FAIL zero_filter_write: got %h want %h", got, want); end
    tick();
    settle();
    checks++;
    if (rf_commit_config !== 1'b0) begin
      errors++; $display("FAIL zero_filter_single: got strobe %b rd %0d want 0", rf_commit_config, rf_rd);
    end
    tick();
  endtask

  task automatic test_full();
    int         p = 0;
    bit         saw_full = 1'b0;
    bit         acc;
    logic [4:0] seen[$];
    clear_inputs();
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (p < 3) retire(5'(10 + 2 * p), 32'(256 + 2 * p), 4'(2 * p), 1'b1,
                        5'(11 + 2 * p), 32'(257 + 2 * p), 4'(2 * p + 1));
      else clear_inputs();
      settle();
      checks++;
      if (commit_ready !== exp_ready) begin
        errors++; $display("FAIL full_ready_c%0d: got %b want %b", cyc, commit_ready, exp_ready);
      end
      if (mq.size() == 3 && commit_ready === 1'b0) saw_full = 1'b1;
      if (rf_commit_config === 1'b1) seen.push_back(rf_rd);
      acc = commit_ready;
      tick();
      if (acc && p < 3) p++;
    end
    checks++;
    if (!saw_full || seen.size() != 6) begin
      errors++; $display("FAIL full_summary: got saw_full=%0d writes=%0d want 1/6", saw_full, seen.size());
    end
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== 5'(10 + i)) begin
        errors++; $display("FAIL full_order_%0d: got x%0d want x%0d", i, seen[i], 10 + i);
      end
    end
  endtask

  task automatic test_bypass();
    clear_inputs();
    retire(5'd5, 32'h11, 4'd1, 1'b1, 5'd5, 32'h33, 4'd2);
    settle(); tick();
    clear_inputs();
    rdy = 1'b0; rs1_index = 5'd5; rs2_index = 5'd0;
    settle();
    got = 128'({rs1_hit, rs1_val, rs2_hit, rf_commit_config, commit_ready});
    want = 128'({1'b1, 32'h33, 1'b0, 1'b0, 1'b0});
    checks++;
    if (got !== want) begin errors++; $display("FAIL bypass_frozen: got %h want %h", got, want); end
    tick();
    rdy = 1'b1;
    settle();
    got = 128'({rf_commit_config, rf_val, rs1_hit, rs1_val});
    want = 128'({1'b1, 32'h11, 1'b1, 32'h33});
    checks++;
    if (got !== want) begin errors++; $display("FAIL bypass_pop_old: got %h want %h", got, want); end
    tick();
    settle();
    got = 128'({rf_commit_config, rf_val, rs1_hit, rs1_val});
    want = 128'({1'b1, 32'h33, 1'b1, 32'h33});
    checks++;
    if (got !== want) begin errors++; $display("FAIL bypass_pop_head: got %h want %h", got, want); end
    tick();
    settle();
    checks++;
    if (rs1_hit !== 1'b0) begin errors++; $display("FAIL bypass_empty: got %b want 0", rs1_hit); end
    tick();
  endtask

  task automatic test_rollback();
    clear_inputs();
    retire(5'd1, 32'h1, 4'd1, 1'b1, 5'd2, 32'h2, 4'd2);
    settle(); tick();
    retire(5'd3, 32'h3, 4'd3, 1'b1, 5'd4, 32'h4, 4'd4);
    settle(); tick();
    clear_inputs();
    rollback_in = 1'b1;
    settle();
    got = 128'({decode_stall, rf_rollback, rf_rd});
    want = 128'({1'b1, 1'b0, 5'd2});
    checks++;
    if (got !== want) begin errors++; $display("FAIL rb_pulse_cycle: got %h want %h", got, want); end
    tick();
    clear_inputs();
    retire(5'd9, 32'h9, 4'd9, 1'b0, 5'd0, 32'h0, 4'd0);
    settle();
    got = 128'({decode_stall, commit_ready, rf_rollback, rf_rd});
    want = 128'({1'b1, 1'b0, 1'b0, 5'd3});
    checks++;
    if (got !== want) begin errors++; $display("FAIL rb_pending: got %h want %h", got, want); end
    tick();
    clear_inputs();
    settle();
    got = 128'({decode_stall, rf_rollback, rf_commit_config, rf_rd});
    want = 128'({1'b1, 1'b1, 1'b1, 5'd4});
    checks++;
    if (got !== want) begin errors++; $display("FAIL rb_with_last: got %h want %h", got, want); end
    tick();
    settle();
    got = 128'({decode_stall, rf_rollback, rf_commit_config, commit_ready});
    want = 128'({1'b0, 1'b0, 1'b0, 1'b1});
    checks++;
    if (got !== want) begin errors++; $display("FAIL rb_released: got %h want %h", got, want); end
    tick();
  endtask

  task automatic test_freeze_reset();
    clear_inputs();
    retire(5'd11, 32'hb, 4'd1, 1'b1, 5'd12, 32'hc, 4'd2);
    settle(); tick();
    retire(5'd13, 32'hd, 4'd3, 1'b1, 5'd14, 32'he, 4'd4);
    settle(); tick();
    clear_inputs();
    rdy = 1'b0; rs1_index = 5'd14;
    for (int i = 0; i < 3; i++) begin
      settle();
      got = 128'({rf_commit_config, rf_rollback, commit_ready, rs1_hit, rs1_val});
      want = 128'({1'b0, 1'b0, 1'b0, 1'b1, 32'he});
      checks++;
      if (got !== want) begin errors++; $display("FAIL freeze_c%0d: got %h want %h", i, got, want); end
      tick();
    end
    rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      got = 128'({rf_commit_config, rf_rd});
      want = 128'({1'b1, 5'(12 + i)});
      checks++;
      if (got !== want) begin errors++; $display("FAIL resume_%0d: got %h want %h", i, got, want); end
      tick();
    end
    rst = 1'b1;
    settle(); tick();
    rst = 1'b0;
    settle();
    got = 128'({commit_ready, rf_commit_config, rf_rd, rf_val, rf_rob, rf_rollback,
                rs1_hit, decode_stall});
    want = 128'({1'b1, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0});
    checks++;
    if (got !== want) begin errors++; $display("FAIL reset_mid_drain: got %h want %h", got, want); end
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst         = ($urandom_range(0, 99) == 0);
      rdy         = ($urandom_range(0, 9) != 0);
      rollback_in = ($urandom_range(0, 19) == 0);
      c0_valid    = ($urandom_range(0, 2) != 0);
      c1_valid    = c0_valid && ($urandom_range(0, 1) == 1);
      c0_rd = 5'($urandom_range(0, 7)); c0_val = $urandom; c0_rob = 4'($urandom_range(0, 15));
      c1_rd = 5'($urandom_range(0, 7)); c1_val = $urandom; c1_rob = 4'($urandom_range(0, 15));
      rs1_index = 5'($urandom_range(0, 7));
      rs2_index = 5'($urandom_range(0, 7));
      settle();
      got = 128'({commit_ready, rf_commit_config, rf_rd, rf_val, rf_rob, rf_rollback,
                  decode_stall, rs1_hit, rs1_hit ? rs1_val : 32'd0,
                  rs2_hit, rs2_hit ? rs2_val : 32'd0});
      want = 128'({exp_ready, exp_wr, exp_rd, exp_val, exp_rob, exp_rb,
                   exp_stall, exp_h1, exp_v1, exp_h2, exp_v2});
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL random_c%0d: got %h want %h", cyc, got, want);
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    m_rb = 1'b0;
    test_reset();
    test_dual_retire();
    test_zero_filter();
    test_full();
    test_bypass();
    test_rollback();
    test_freeze_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
